// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: opcodes, FSM states, fixed words
// and the conditional-jump decode.
package fetch_unit_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_JZRS = 4'b0110;
   localparam logic [3:0] OP_JZIM = 4'b0111;
   localparam logic [3:0] OP_JCRS = 4'b1000;
   localparam logic [3:0] OP_JCIM = 4'b1010;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [7:0] NOP_WORD  = {OP_NOP, 4'h0};
   localparam logic [7:0] HALT_WORD = {OP_HALT, 4'h0};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   // True when the opcode is a conditional jump whose flag is set.
   function automatic logic jump_cond(input logic [3:0] op, input logic z, input logic c);
      logic res;
      res = 1'b0;
      case (op)
         OP_JZRS, OP_JZIM: res = z;
         OP_JCRS, OP_JCIM: res = c;
         default:          res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read channel between the fetch unit and its memory.
interface fetch_unit_if;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       imem_ack;

   modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
   modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_timer.sv
// Counts WAIT cycles without an acknowledge; expired flags the cycle whose
// tick would bring the count to TIMEOUT.
module fetch_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic CLB,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // Wait-cycle counter, saturating at TIMEOUT.
   always_ff @(posedge clk or posedge CLB) begin
      if (CLB) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CW'(TIMEOUT))) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter with conditional jumps, and a
// request/acknowledge fetch FSM with a sticky memory-timeout fault.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         CLB,
   fetch_unit_if.master mem,
   input  logic         LoadIR,
   input  logic         IncPC,
   input  logic         SelPC,
   input  logic         LoadPC,
   input  logic         z,
   input  logic         c,
   input  logic [7:0]   reg_data,
   output logic [7:0]   pc,
   output logic [7:0]   ir,
   output logic [3:0]   op,
   output logic [3:0]   arg,
   output logic         fetch_busy,
   output logic         ir_valid,
   output logic         jump_taken,
   output logic         fetch_fault
);

   fetch_state_t state;
   logic         tmr_clear;
   logic         tmr_enable;
   logic         tmr_expired;
   logic         take_jump;

   assign op  = ir[7:4];
   assign arg = ir[3:0];

   assign take_jump  = LoadPC && jump_cond(op, z, c);
   assign tmr_clear  = (state == ST_IDLE) && LoadIR;
   assign tmr_enable = (state == ST_WAIT) && !mem.imem_ack;

   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .CLB     (CLB),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   // Program counter: a taken jump wins; a blocked jump also blocks increment.
   always_ff @(posedge clk or posedge CLB) begin
      if (CLB) begin
         pc         <= 8'h00;
         jump_taken <= 1'b0;
      end else begin
         jump_taken <= 1'b0;
         if (LoadPC) begin
            if (take_jump) begin
               pc         <= SelPC ? reg_data : {4'b0000, arg};
               jump_taken <= 1'b1;
            end
         end else if (IncPC) begin
            pc <= pc + 8'd1;
         end
      end
   end

   // Fetch FSM; the address is latched at request time so pc may move freely.
   always_ff @(posedge clk or posedge CLB) begin
      if (CLB) begin
         state         <= ST_IDLE;
         ir            <= NOP_WORD;
         mem.imem_req  <= 1'b0;
         mem.imem_addr <= 8'h00;
         fetch_busy    <= 1'b0;
         ir_valid      <= 1'b0;
         fetch_fault   <= 1'b0;
      end else begin
         ir_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (LoadIR) begin
                  state         <= ST_WAIT;
                  mem.imem_req  <= 1'b1;
                  mem.imem_addr <= pc;
                  fetch_busy    <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (mem.imem_ack) begin
                  state        <= ST_IDLE;
                  ir           <= mem.imem_rdata;
                  mem.imem_req <= 1'b0;
                  fetch_busy   <= 1'b0;
                  ir_valid     <= 1'b1;
               end else if (tmr_expired) begin
                  state        <= ST_FAULT;
                  ir           <= HALT_WORD;
                  mem.imem_req <= 1'b0;
                  fetch_busy   <= 1'b0;
                  fetch_fault  <= 1'b1;
               end
            end
            ST_FAULT: begin
               mem.imem_req <= 1'b0;
               fetch_busy   <= 1'b0;
               fetch_fault  <= 1'b1;
               ir           <= HALT_WORD;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios and randomized traffic,
// compared each cycle against a behavioural model of the fetch unit.
module tb_fetch_unit;
   localparam int TIMEOUT = 15;

   logic       clk;
   logic       CLB;
   logic       LoadIR, IncPC, SelPC, LoadPC, z, c;
   logic [7:0] reg_data;
   logic [7:0] pc, ir;
   logic [3:0] op, arg;
   logic       fetch_busy, ir_valid, jump_taken, fetch_fault;

   fetch_unit_if mem_bus ();

   fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .CLB         (CLB),
      .mem         (mem_bus),
      .LoadIR      (LoadIR),
      .IncPC       (IncPC),
      .SelPC       (SelPC),
      .LoadPC      (LoadPC),
      .z           (z),
      .c           (c),
      .reg_data    (reg_data),
      .pc          (pc),
      .ir          (ir),
      .op          (op),
      .arg         (arg),
      .fetch_busy  (fetch_busy),
      .ir_valid    (ir_valid),
      .jump_taken  (jump_taken),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [7:0] m_pc, m_ir, m_addr;
   logic       m_req, m_busy, m_irv, m_jt, m_fault;
   bit         m_inflight, m_faulted;
   int         m_waits;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_ir = 8'h00; m_addr = 8'h00;
      m_req = 1'b0; m_busy = 1'b0; m_irv = 1'b0; m_jt = 1'b0; m_fault = 1'b0;
      m_inflight = 1'b0; m_faulted = 1'b0; m_waits = 0;
   endtask

   // One clock edge of behaviour, using the inputs present at that edge.
   task automatic model_step();
      logic [3:0] mop;
      bit         cond;
      logic [7:0] old_pc;
      mop    = m_ir[7:4];
      cond   = (z && (mop == 4'h6 || mop == 4'h7)) || (c && (mop == 4'h8 || mop == 4'hA));
      old_pc = m_pc;
      m_jt   = 1'b0;
      if (LoadPC) begin
         if (cond) begin
            m_pc = SelPC ? reg_data : {4'h0, m_ir[3:0]};
            m_jt = 1'b1;
         end
      end else if (IncPC) begin
         m_pc = 8'((int'(m_pc) + 1) % 256);
      end
      m_irv = 1'b0;
      if (m_faulted) begin
         // nothing but reset leaves the fault
      end else if (!m_inflight) begin
         if (LoadIR) begin
            m_inflight = 1'b1; m_req = 1'b1; m_busy = 1'b1; m_addr = old_pc; m_waits = 0;
         end
      end else if (mem_bus.imem_ack) begin
         m_inflight = 1'b0; m_req = 1'b0; m_busy = 1'b0; m_irv = 1'b1;
         m_ir = mem_bus.imem_rdata;
      end else begin
         m_waits++;
         if (m_waits >= TIMEOUT) begin
            m_faulted = 1'b1; m_inflight = 1'b0; m_req = 1'b0; m_busy = 1'b0;
            m_fault = 1'b1; m_ir = 8'hF0;
         end
      end
   endtask

   task automatic compare_all(input string where);
      check({where, ".pc"},          pc,                m_pc);
      check({where, ".ir"},          ir,                m_ir);
      check({where, ".op"},          op,                m_ir[7:4]);
      check({where, ".arg"},         arg,               m_ir[3:0]);
      check({where, ".imem_req"},    mem_bus.imem_req,  m_req);
      check({where, ".imem_addr"},   mem_bus.imem_addr, m_addr);
      check({where, ".fetch_busy"},  fetch_busy,        m_busy);
      check({where, ".ir_valid"},    ir_valid,          m_irv);
      check({where, ".jump_taken"},  jump_taken,        m_jt);
      check({where, ".fetch_fault"}, fetch_fault,       m_fault);
   endtask

   // Advance one edge, then compare 1 time unit later.
   task automatic cycle(input string where);
      @(posedge clk);
      model_step();
      #1;
      compare_all(where);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      #2;
      CLB = 1'b1;
      #1;
      model_reset();
      compare_all("reset");
      #2;
      CLB = 1'b0;
   endtask

   task automatic idle_inputs();
      LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; z = 0; c = 0; reg_data = 8'h00;
      mem_bus.imem_ack = 0; mem_bus.imem_rdata = 8'h00;
   endtask

   // Fetch one word with the ack in the cycle right after the request.
   task automatic fetch_word(input logic [7:0] w);
      LoadIR = 1; cycle("fetch_req"); LoadIR = 0;
      mem_bus.imem_ack = 1; mem_bus.imem_rdata = w; cycle("fetch_ack");
      mem_bus.imem_ack = 0;
   endtask

   initial begin
      CLB = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // basic fetch
      LoadIR = 1; cycle("f1_req"); LoadIR = 0;
      check("f1_busy_hi", fetch_busy, 1'b1);
      check("f1_addr", mem_bus.imem_addr, 8'h00);
      mem_bus.imem_ack = 1; mem_bus.imem_rdata = 8'h6A; cycle("f1_ack");
      check("f1_ir", ir, 8'h6A);
      check("f1_valid", ir_valid, 1'b1);
      check("f1_busy_lo", fetch_busy, 1'b0);
      mem_bus.imem_ack = 0; cycle("f1_after");
      check("f1_valid_pulse", ir_valid, 1'b0);

      // JZIM 3, taken then not taken
      IncPC = 1; cycle("inc"); cycle("inc"); IncPC = 0;
      fetch_word(8'h73);
      z = 1; LoadPC = 1; SelPC = 0; cycle("jzim_t");
      check("jzim_pc", pc, 8'h03);
      check("jzim_jt", jump_taken, 1'b1);
      LoadPC = 0; cycle("jzim_idle");
      check("jzim_jt_pulse", jump_taken, 1'b0);
      z = 0; LoadPC = 1; cycle("jzim_nt");
      check("jzim_nt_pc", pc, 8'h03);
      check("jzim_nt_jt", jump_taken, 1'b0);
      LoadPC = 0;

      // JCRS with simultaneous IncPC; then blocked jump must not increment
      fetch_word(8'h80);
      c = 1; reg_data = 8'hC4; LoadPC = 1; SelPC = 1; IncPC = 1; cycle("jcrs");
      check("jcrs_pc", pc, 8'hC4);
      c = 0; cycle("jcrs_blocked");
      check("blocked_pc", pc, 8'hC4);

      // wrap
      c = 1; reg_data = 8'hFF; IncPC = 0; cycle("to_ff");
      c = 0; LoadPC = 0; IncPC = 1; cycle("wrap");
      check("wrap_pc", pc, 8'h00);

      // IncPC during WAIT leaves the in-flight address alone
      IncPC = 0; LoadIR = 1; cycle("w_req"); LoadIR = 0; IncPC = 1;
      for (int i = 0; i < 3; i++) cycle("w_inc");
      check("w_addr", mem_bus.imem_addr, 8'h00);
      IncPC = 0; mem_bus.imem_ack = 1; mem_bus.imem_rdata = 8'h12; cycle("w_ack");
      mem_bus.imem_ack = 0;

      // timeout
      LoadIR = 1; cycle("to_req"); LoadIR = 0;
      for (int i = 0; i < TIMEOUT - 1; i++) cycle("to_wait");
      check("to_not_yet", fetch_fault, 1'b0);
      cycle("to_fault");
      check("to_fault", fetch_fault, 1'b1);
      check("to_ir", ir, 8'hF0);
      check("to_req", mem_bus.imem_req, 1'b0);
      mem_bus.imem_ack = 1; mem_bus.imem_rdata = 8'h33; LoadIR = 1;
      for (int i = 0; i < 4; i++) cycle("to_stuck");
      check("to_stuck_ir", ir, 8'hF0);
      mem_bus.imem_ack = 0; LoadIR = 0;
      do_reset();

      // reset in the middle of WAIT, then a late ack
      LoadIR = 1; cycle("mr_req"); LoadIR = 0; cycle("mr_wait");
      do_reset();
      mem_bus.imem_ack = 1; mem_bus.imem_rdata = 8'h55; cycle("mr_late");
      check("mr_ir", ir, 8'h00);
      check("mr_valid", ir_valid, 1'b0);
      mem_bus.imem_ack = 0; cycle("mr_after");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         LoadIR   = ($urandom_range(0, 1) == 1);
         IncPC    = ($urandom_range(0, 1) == 1);
         LoadPC   = ($urandom_range(0, 3) == 0);
         SelPC    = ($urandom_range(0, 1) == 1);
         z        = ($urandom_range(0, 1) == 1);
         c        = ($urandom_range(0, 1) == 1);
         reg_data = 8'($urandom);
         mem_bus.imem_ack   = ($urandom_range(0, 2) == 0);
         mem_bus.imem_rdata = 8'($urandom);
         if ((i % 500) >= 470) mem_bus.imem_ack = 1'b0;
         cycle("rnd");
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
